coeff_packer: RTL and testbench

COEFF_PACKER -- requirements
Module: coeff_packer

---
 rtl/fifo_types.sv | 24 ++
 rtl/coeff_packer.sv | 100 ++++++++++
 tb/tb_coeff_packer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_types.sv
// ============================================================================
//  Module   : fifo_types
//  Brief    : Shared word/beat types for the FIFO fabric and the coeff packer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_types;

    localparam int FIFO_WIDTH = 8;
    localparam int PACK_WORDS = 4;

    typedef logic [FIFO_WIDTH-1:0]            fifo_word_t;
    typedef logic [PACK_WORDS*FIFO_WIDTH-1:0] fifo_beat_t;
    typedef logic [PACK_WORDS-1:0][FIFO_WIDTH-1:0] fifo_slots_t;

    // One extra bit so a counter can represent the "full" value pack_n.
    function automatic int pack_cnt_width(input int pack_n);
        return $clog2(pack_n) + 1;
    endfunction

endpackage : fifo_types

`default_nettype wire

// File: rtl/coeff_packer.sv
// ============================================================================
//  Module   : coeff_packer
//  Brief    : Packs pack_p words of width_p bits into one output beat, with
//             flush support for zero-padded partial beats.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module coeff_packer
    import fifo_types::*;
#(
    parameter int width_p     = 8,
    parameter int pack_p      = 4,
    parameter int cnt_width_p = pack_cnt_width(pack_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       valid_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       yumi_o,
    input  logic                       flush_i,
    output logic                       valid_o,
    output logic [pack_p*width_p-1:0]  data_o,
    input  logic                       ready_i,
    output logic                       partial_o,
    output logic [cnt_width_p-1:0]     count_o
);

    localparam logic [cnt_width_p-1:0] LAST_SLOT = cnt_width_p'(pack_p - 1);

    logic [pack_p-1:0][width_p-1:0] acc_q;
    logic [pack_p-1:0][width_p-1:0] acc_next;
    logic [cnt_width_p-1:0]         count_q;
    logic [cnt_width_p-1:0]         count_next;
    logic                           flush_pending_q;
    logic                           out_free;
    logic                           drain;
    logic                           pend;
    logic                           full;
    logic                           service;
    logic                           load;

    assign out_free = ~valid_o | ready_i;
    assign drain    = valid_o & ready_i;

    // The last slot may only be filled when the output register can take the
    // beat; a pending flush also blocks intake until the beat can leave.
    assign yumi_o = reset_n_i & valid_i
                  & ((count_q < LAST_SLOT) | out_free)
                  & ~(flush_pending_q & ~out_free);

    always_comb begin
        acc_next = acc_q;
        for (int k = 0; k < pack_p; k++) begin
            if (yumi_o && (count_q == cnt_width_p'(k))) begin
                acc_next[k] = data_i;
            end
        end
    end

    assign count_next = count_q + {{(cnt_width_p-1){1'b0}}, yumi_o};
    assign full       = yumi_o & (count_q == LAST_SLOT);
    assign pend       = flush_pending_q | flush_i;
    // A word completing the beat in the flush cycle wins: normal beat.
    assign service    = pend & out_free & (count_next != '0) & ~full;
    assign load       = full | service;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q           <= '0;
            count_q         <= '0;
            flush_pending_q <= 1'b0;
            valid_o         <= 1'b0;
            partial_o       <= 1'b0;
            data_o          <= '0;
        end else begin
            if (load) begin
                data_o    <= acc_next;
                valid_o   <= 1'b1;
                partial_o <= service;
                acc_q     <= '0;
                count_q   <= '0;
            end else begin
                acc_q   <= acc_next;
                count_q <= count_next;
                if (drain) begin
                    valid_o   <= 1'b0;
                    partial_o <= 1'b0;
                end
            end
            // An empty accumulator has nothing to flush, so the request lapses.
            flush_pending_q <= pend & ~load & (count_next != '0);
        end
    end

    assign count_o = count_q;

endmodule : coeff_packer

`default_nettype wire

// File: tb/tb_coeff_packer.sv
// ============================================================================
//  Module   : tb_coeff_packer
//  Brief    : Directed vectors, corner sequences and a random stream scoreboard.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_coeff_packer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        yumi_o;
    logic        flush_i;
    logic        valid_o;
    logic [31:0] data_o;
    logic        ready_i;
    logic        partial_o;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;

    coeff_packer #(.width_p(8), .pack_p(4)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .yumi_o    (yumi_o),
        .flush_i   (flush_i),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .partial_o (partial_o),
        .count_o   (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        r;
        logic        e_yumi;
        logic        e_vo;
        logic [31:0] e_do;
        logic        e_p;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Random-stream scoreboard state
    logic [7:0]  in_q [$];
    logic        prev_stall;
    logic [33:0] prev_out;

    task automatic score_cycle();
        logic       ok;
        logic       seen_zero;
        int         nwords;
        logic [7:0] w;
        if (prev_stall)
            chk("stall_stable", {valid_o, partial_o, data_o}, prev_out);
        if (count_o == 3'd3 && valid_o && !ready_i)
            chk("last_slot_block", {31'd0, yumi_o}, 32'd0);
        if (yumi_o) in_q.push_back(data_i);
        if (valid_o && ready_i) begin
            ok = 1'b1; seen_zero = 1'b0; nwords = 0;
            for (int k = 0; k < 4; k++) begin
                w = data_o[k*8 +: 8];
                if (w == 8'h00) seen_zero = 1'b1;
                else begin
                    if (seen_zero) ok = 1'b0;
                    if (in_q.size() == 0) ok = 1'b0;
                    else if (in_q.pop_front() != w) ok = 1'b0;
                    nwords++;
                end
            end
            if (partial_o) ok = ok & (nwords > 0) & (nwords < 4);
            else           ok = ok & (nwords == 4);
            chk("stream_beat", {31'd0, ok}, 32'd1);
        end
        prev_stall = valid_o & ~ready_i;
        prev_out   = {valid_o, partial_o, data_o};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cyc;

        //            v  d      f  r   yumi vo  data_o        p  cnt
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 3'd1};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 3'd2};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, 3'd3};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h44332211, 1'b0, 3'd0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44332211, 1'b0, 3'd0};
        tbl[6]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44332211, 1'b0, 3'd0};
        tbl[7]  = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44332211, 1'b0, 3'd1};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h44332211, 1'b0, 3'd2};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000BBAA, 1'b1, 3'd0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000BBAA, 1'b0, 3'd0};
        tbl[11] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BBAA, 1'b0, 3'd0};
        tbl[12] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BBAA, 1'b0, 3'd1};
        tbl[13] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000BBAA, 1'b0, 3'd2};
        tbl[14] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000BBAA, 1'b0, 3'd3};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 32'h04030201, 1'b0, 3'd0};
        tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h04030201, 1'b0, 3'd0};

        reset_n_i = 1'b0; valid_i = 1'b1; data_i = 8'h5A; flush_i = 1'b0; ready_i = 1'b1;
        prev_stall = 1'b0; prev_out = '0;
        repeat (2) @(negedge clk_i);
        #2;
        chk("reset_count",   {29'd0, count_o},  32'd0);
        chk("reset_valid",   {31'd0, valid_o},  32'd0);
        chk("reset_partial", {31'd0, partial_o}, 32'd0);
        chk("reset_data",    data_o,             32'd0);
        chk("reset_yumi",    {31'd0, yumi_o},   32'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1; valid_i = 1'b0;

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_i);
            valid_i = tbl[i].v; data_i = tbl[i].d; flush_i = tbl[i].f; ready_i = tbl[i].r;
            #2;
            chk($sformatf("vec%0d_yumi", i),    {31'd0, yumi_o},    {31'd0, tbl[i].e_yumi});
            chk($sformatf("vec%0d_valid", i),   {31'd0, valid_o},   {31'd0, tbl[i].e_vo});
            chk($sformatf("vec%0d_data", i),    data_o,              tbl[i].e_do);
            chk($sformatf("vec%0d_partial", i), {31'd0, partial_o}, {31'd0, tbl[i].e_p});
            chk($sformatf("vec%0d_count", i),   {29'd0, count_o},   {29'd0, tbl[i].e_cnt});
        end
        flush_i = 1'b0;

        // Backpressure: 8 words, ready held low until cycle 10
        idx = 0;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk_i);
            valid_i = (idx < 8);
            data_i  = 8'h81 + 8'(idx);
            ready_i = (c >= 10);
            #2;
            if (c >= 7 && c <= 9) chk($sformatf("bp_hold_yumi_c%0d", c), {31'd0, yumi_o}, 32'd0);
            if (c == 10)          chk("bp_release_yumi", {31'd0, yumi_o}, 32'd1);
            if (c >= 4 && c <= 10) begin
                chk($sformatf("bp_beat1_c%0d", c), {valid_o, partial_o, data_o},
                    {1'b1, 1'b0, 32'h84838281});
            end
            if (c == 11) chk("bp_beat2", {valid_o, partial_o, data_o}, {1'b1, 1'b0, 32'h88878685});
            if (c == 12) chk("bp_drained", {31'd0, valid_o}, 32'd0);
            if (yumi_o) idx++;
        end
        chk("bp_words_taken", idx, 32'd8);

        // Reset in the middle of a beat with a flush outstanding
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            valid_i = 1'b1; data_i = 8'h55 + 8'(i * 17); ready_i = 1'b0;
        end
        @(negedge clk_i);
        valid_i = 1'b1; data_i = 8'h77; flush_i = 1'b1; reset_n_i = 1'b0;
        #2;
        chk("mid_reset_outputs", {yumi_o, valid_o, partial_o, count_o, data_o}, 38'd0);
        @(negedge clk_i);
        #2;
        chk("mid_reset_held", {yumi_o, valid_o, partial_o, count_o, data_o}, 38'd0);
        @(negedge clk_i);
        reset_n_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = 8'hA1 + 8'(i);
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        #2;
        chk("post_reset_beat", {valid_o, partial_o, data_o}, {1'b1, 1'b0, 32'hA4A3A2A1});

        // Random stream against the ordering scoreboard
        idx = 0; cyc = 0; prev_stall = 1'b0;
        while (idx < 1000 && cyc < 6000) begin
            @(negedge clk_i);
            valid_i = ($urandom_range(0, 3) != 0);
            data_i  = 8'($urandom_range(1, 255));
            ready_i = $urandom_range(0, 1) != 0;
            flush_i = ($urandom_range(0, 15) == 0);
            #2;
            if (yumi_o) idx++;
            score_cycle();
            cyc++;
        end
        chk("stream_words_accepted", {31'd0, idx >= 1000}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            valid_i = 1'b0; ready_i = 1'b1; flush_i = (c == 1);
            #2;
            score_cycle();
        end
        chk("stream_leftover", in_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_coeff_packer

`default_nettype wire
